// File: rtl/video_ctrl_pkg.sv
// video_ctrl_pkg: config register map, CSC encodings, scheduler state and config record.
package video_ctrl_pkg;
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_MSTART = 3'd1;
    localparam logic [2:0] ADDR_MEND   = 3'd2;
    localparam logic [2:0] ADDR_DWELL  = 3'd3;
    localparam logic [2:0] ADDR_CSC    = 3'd4;
    localparam logic [2:0] ADDR_LOOPS  = 3'd5;

    localparam logic [1:0] CSC_RGB2YUV = 2'b00;
    localparam logic [1:0] CSC_YUV2RGB = 2'b01;
    localparam logic [1:0] CSC_RGB2RGB = 2'b10;
    localparam logic [1:0] CSC_RSVD    = 2'b11;

    localparam int CTRL_AP_EN = 0;
    localparam int CTRL_AUTO  = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [3:0] mstart;
        logic [3:0] mend;
        logic [7:0] dwell;
        logic [1:0] csc;
        logic [7:0] loops;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{ctrl: 2'b00, mstart: 4'd0, mend: 4'd0, dwell: 8'd1,
                                   csc: CSC_RGB2YUV, loops: 8'd0};

    // A dwell of zero frames is meaningless; treat it as one.
    function automatic logic [7:0] eff_dwell(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction
endpackage

// File: rtl/frame_mode_scheduler_if.sv
// frame_mode_scheduler_if: host config write / commit port of the frame mode scheduler.
interface frame_mode_scheduler_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_commit;
    logic       commit_pending;

    modport master (output cfg_valid, cfg_addr, cfg_wdata, cfg_commit,
                    input  cfg_ready, commit_pending);
    modport slave  (input  cfg_valid, cfg_addr, cfg_wdata, cfg_commit,
                    output cfg_ready, commit_pending);
endinterface

// File: rtl/vsync_edge_det.sv
// vsync_edge_det: polarity-normalised vsync with a one-cycle rising-edge pulse.
module vsync_edge_det #(
    parameter bit VS_POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vsync,
    output logic o_vs_rise
);
    logic w_vs;
    logic r_vs_d;

    assign w_vs = i_vsync ~^ VS_POL;

    // Delayed copy resets to active so a vsync already asserted out of reset is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) r_vs_d <= 1'b1;
        else        r_vs_d <= w_vs;
    end

    assign o_vs_rise = w_vs & ~r_vs_d;
endmodule

// File: rtl/frame_mode_scheduler.sv
// frame_mode_scheduler: frame-synchronous config commit and AP/CSC mode sequencer.
// Host writes land in shadow regs; a commit copies them to the active set at the next vsync rise.
module frame_mode_scheduler
    import video_ctrl_pkg::*;
#(
    parameter bit VS_POL = 1'b1,
    parameter int FCNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            i_sync,
    input  logic                  i_run,
    frame_mode_scheduler_if.slave cfg,
    output logic                  o_ap_en,
    output logic [3:0]            o_ap_mode,
    output logic [1:0]            o_csc_mode,
    output logic                  o_frame_pulse,
    output logic [FCNT_W-1:0]     o_frame_cnt,
    output logic                  o_seq_done
);
    cfg_t              r_shadow, r_active;
    state_t            r_state, w_state_nx;
    logic [3:0]        r_mode, w_mode_nx;
    logic [7:0]        r_dwell_cnt, w_dwell_nx;
    logic [7:0]        r_loop_cnt, w_loop_nx;
    logic              r_seq_done, w_done_nx;
    logic              r_pending, r_frame_pulse;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              w_vs_rise, w_wr, w_apply, w_dwell_end, w_wrap, w_last;
    logic              w_unused_sync;

    assign w_unused_sync = |i_sync[1:0];

    vsync_edge_det #(.VS_POL(VS_POL)) u_vs_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vsync   (i_sync[2]),
        .o_vs_rise (w_vs_rise)
    );

    assign w_wr               = cfg.cfg_valid & cfg.cfg_ready;
    assign w_apply            = w_vs_rise & i_run & r_pending;
    assign cfg.cfg_ready      = !r_pending;
    assign cfg.commit_pending = r_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) r_shadow <= CFG_RESET;
        else if (w_wr) begin
            case (cfg.cfg_addr)
                ADDR_CTRL:   r_shadow.ctrl   <= cfg.cfg_wdata[1:0];
                ADDR_MSTART: r_shadow.mstart <= cfg.cfg_wdata[3:0];
                ADDR_MEND:   r_shadow.mend   <= cfg.cfg_wdata[3:0];
                ADDR_DWELL:  r_shadow.dwell  <= cfg.cfg_wdata;
                ADDR_CSC:    if (cfg.cfg_wdata[1:0] != CSC_RSVD) r_shadow.csc <= cfg.cfg_wdata[1:0];
                ADDR_LOOPS:  r_shadow.loops  <= cfg.cfg_wdata;
                default:     ;
            endcase
        end
    end

    // A commit arriving on the applying edge stays pending for the following frame.
    always_ff @(posedge clk) begin
        if (!rst_n)          r_pending <= 1'b0;
        else if (w_apply)    r_pending <= cfg.cfg_commit;
        else if (cfg.cfg_commit) r_pending <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       r_active <= CFG_RESET;
        else if (w_apply) r_active <= r_shadow;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_pulse <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_pulse <= w_vs_rise;
            r_frame_cnt   <= w_vs_rise ? r_frame_cnt + FCNT_W'(1) : r_frame_cnt;
        end
    end

    assign w_dwell_end = r_dwell_cnt >= eff_dwell(r_active.dwell) - 8'd1;
    assign w_wrap      = r_mode == r_active.mend;
    assign w_last      = (r_active.loops != 8'd0) && (r_loop_cnt + 8'd1 == r_active.loops);

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_dwell_nx = r_dwell_cnt;
        w_loop_nx  = r_loop_cnt;
        w_done_nx  = r_seq_done;
        if (!i_run) w_state_nx = IDLE;
        else if (w_apply) begin
            w_state_nx = RUN;
            w_mode_nx  = r_shadow.mstart;
            w_dwell_nx = 8'd0;
            w_loop_nx  = 8'd0;
            w_done_nx  = 1'b0;
        end else if (w_vs_rise) begin
            case (r_state)
                IDLE: w_state_nx = r_seq_done ? DONE : RUN;
                RUN: begin
                    w_dwell_nx = w_dwell_end ? 8'd0 : r_dwell_cnt + 8'd1;
                    if (w_dwell_end && r_active.ctrl[CTRL_AUTO]) begin
                        w_mode_nx = w_wrap ? r_active.mstart : r_mode + 4'd1;
                        w_loop_nx = w_wrap ? r_loop_cnt + 8'd1 : r_loop_cnt;
                        if (w_wrap && w_last) begin
                            w_state_nx = DONE;
                            w_mode_nx  = r_mode;
                            w_done_nx  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mode      <= 4'd0;
            r_dwell_cnt <= 8'd0;
            r_loop_cnt  <= 8'd0;
            r_seq_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_mode      <= w_mode_nx;
            r_dwell_cnt <= w_dwell_nx;
            r_loop_cnt  <= w_loop_nx;
            r_seq_done  <= w_done_nx;
        end
    end

    assign o_ap_en       = r_active.ctrl[CTRL_AP_EN];
    assign o_ap_mode     = r_mode;
    assign o_csc_mode    = r_active.csc;
    assign o_frame_pulse = r_frame_pulse;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_seq_done    = r_seq_done;
endmodule

// File: tb/tb_frame_mode_scheduler.sv
// tb_frame_mode_scheduler: directed frames with expected per-frame outputs checked by a frame_pulse monitor.
module tb_frame_mode_scheduler;
    import video_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [2:0]  sync = 3'b000;
    logic        ap_en, frame_pulse, seq_done;
    logic [3:0]  ap_mode;
    logic [1:0]  csc_mode;
    logic [15:0] frame_cnt;

    frame_mode_scheduler_if bus();

    frame_mode_scheduler #(.VS_POL(1'b1), .FCNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sync        (sync),
        .i_run         (run),
        .cfg           (bus),
        .o_ap_en       (ap_en),
        .o_ap_mode     (ap_mode),
        .o_csc_mode    (csc_mode),
        .o_frame_pulse (frame_pulse),
        .o_frame_cnt   (frame_cnt),
        .o_seq_done    (seq_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic        en;
        logic [3:0]  mode;
        logic [1:0]  csc;
        logic        done;
        logic [15:0] fcnt;
    } exp_t;

    exp_t       q[$];
    exp_t       e_mon;
    int         n_vec = 0;
    int         n_bad = 0;
    int         fc = 0;
    logic [3:0] seq2 [8]  = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd2, 4'd2};
    logic [3:0] seq3 [10] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0, 4'd1, 4'd1, 4'd1};

    // Scoreboard monitor: every frame_pulse consumes one expectation.
    always @(negedge clk) begin
        if (frame_pulse) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL frame_unexpected: got frame_pulse at fcnt=%0d, want none", frame_cnt);
            end else begin
                e_mon = q.pop_front();
                if (e_mon.chk) begin
                    n_vec++;
                    if ({ap_en, ap_mode, csc_mode, seq_done, frame_cnt} !==
                        {e_mon.en, e_mon.mode, e_mon.csc, e_mon.done, e_mon.fcnt}) begin
                        n_bad++;
                        $display("FAIL frame%0d: got en=%0b mode=%0d csc=%0d done=%0b fcnt=%0d, want en=%0b mode=%0d csc=%0d done=%0b fcnt=%0d",
                                 e_mon.fcnt, ap_en, ap_mode, csc_mode, seq_done, frame_cnt,
                                 e_mon.en, e_mon.mode, e_mon.csc, e_mon.done, e_mon.fcnt);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        bus.cfg_commit = 1'b1;
        @(negedge clk);
        bus.cfg_commit = 1'b0;
    endtask

    task automatic frame(input logic c, input logic en, input logic [3:0] mode,
                         input logic [1:0] csc, input logic done, input logic cm);
        @(negedge clk);
        fc++;
        q.push_back('{c, en, mode, csc, done, 16'(fc)});
        sync = 3'b100;
        bus.cfg_commit = cm;
        @(negedge clk);
        bus.cfg_commit = 1'b0;
        @(negedge clk);
        sync = 3'b000;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_addr   = 3'd0;
        bus.cfg_wdata  = 8'd0;
        bus.cfg_commit = 1'b0;
        sync = 3'b100;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({ap_en, ap_mode, csc_mode, seq_done, frame_pulse, frame_cnt}), 32'd0);
        chk("reset_handshake", 32'({bus.cfg_ready, bus.commit_pending}), 32'b10);
        rst_n = 1'b1;
        run = 1'b1;
        repeat (4) @(negedge clk);
        chk("vsync_high_from_reset", 32'(frame_cnt), 32'd0);
        sync = 3'b000;
        repeat (3) @(negedge clk);

        wr(ADDR_CTRL, 8'h03);
        wr(ADDR_MSTART, 8'd2);
        wr(ADDR_MEND, 8'd4);
        wr(ADDR_DWELL, 8'd2);
        wr(ADDR_LOOPS, 8'd0);
        commit();
        chk("pending_after_commit", 32'({bus.cfg_ready, bus.commit_pending, ap_en}), 32'b010);
        for (int i = 0; i < 8; i++) frame(1'b1, 1'b1, seq2[i], 2'd0, 1'b0, 1'b0);
        chk("pending_cleared", 32'({bus.cfg_ready, bus.commit_pending}), 32'b10);

        wr(ADDR_MSTART, 8'd14);
        wr(ADDR_MEND, 8'd1);
        wr(ADDR_DWELL, 8'd1);
        wr(ADDR_LOOPS, 8'd2);
        commit();
        for (int i = 0; i < 10; i++) frame(1'b1, 1'b1, seq3[i], 2'd0, i >= 8, 1'b0);

        wr(ADDR_CSC, 8'd1);
        wr(ADDR_CSC, 8'd3);
        commit();
        chk("csc_hold_mid_frame", 32'({csc_mode, bus.cfg_ready, bus.commit_pending}), 32'b0001);
        wr(ADDR_CSC, 8'd2);
        frame(1'b1, 1'b1, 4'd14, 2'd1, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 4'd15, 2'd1, 1'b0, 1'b0);

        wr(ADDR_CSC, 8'd2);
        wr(ADDR_MSTART, 8'd5);
        frame(1'b1, 1'b1, 4'd0, 2'd1, 1'b0, 1'b1);
        chk("commit_on_vs_rise_pending", 32'(bus.commit_pending), 32'd1);
        frame(1'b1, 1'b1, 4'd5, 2'd2, 1'b0, 1'b0);
        chk("commit_on_vs_rise_cleared", 32'(bus.commit_pending), 32'd0);

        wr(ADDR_MSTART, 8'd7);
        wr(ADDR_MEND, 8'd9);
        wr(ADDR_DWELL, 8'd3);
        wr(ADDR_LOOPS, 8'd0);
        commit();
        frame(1'b1, 1'b1, 4'd7, 2'd2, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 4'd7, 2'd2, 1'b0, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 3; i++) frame(1'b1, 1'b1, 4'd7, 2'd2, 1'b0, 1'b0);
        chk("run0_frame_cnt", 32'(frame_cnt), 32'(fc));
        run = 1'b1;
        frame(1'b1, 1'b1, 4'd7, 2'd2, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 4'd7, 2'd2, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 4'd8, 2'd2, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset_outputs", 32'({ap_en, ap_mode, csc_mode, seq_done, frame_pulse, frame_cnt}), 32'd0);
        chk("midrun_reset_handshake", 32'({bus.cfg_ready, bus.commit_pending}), 32'b10);
        fc = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
